// File: rtl/led_pwm_sb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_ctrl_pkg
// Brief    : Register map, mode encoding and decode helper for led_pwm_sb_ctrl
// Revision : 1.0 - initial release
// ============================================================================
package led_ctrl_pkg;

  localparam logic [31:0] LED_VAL_ADDR  = 32'h0000_0000;
  localparam logic [31:0] LED_MODE_ADDR = 32'h0000_0004;
  localparam logic [31:0] LED_DUTY_ADDR = 32'h0000_0008;
  localparam logic [31:0] LED_HALF_ADDR = 32'h0000_000C;
  localparam logic [31:0] LED_RST_ADDR  = 32'h0000_0024;

  localparam int MODE_BLINK_BIT = 0;
  localparam int MODE_DIM_BIT   = 1;

  typedef enum logic [1:0] {
    STATIC    = 2'd0,
    BLINK     = 2'd1,
    DIM       = 2'd2,
    BLINK_DIM = 2'd3
  } led_mode_e;

  // True when value is representable in the given number of bits.
  function automatic logic fits_bits(input logic [31:0] value, input int width);
    return (value >> width) == 32'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_pwm_sb_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : led_pwm_sb_ctrl_if
// Brief    : System-bus slave port bundle for the LED peripheral
// Revision : 1.0 - initial release
// ============================================================================
interface led_pwm_sb_ctrl_if;
  logic        req_i;
  logic        write_enable_i;
  logic [31:0] addr_i;
  logic [31:0] write_data_i;
  logic [31:0] read_data_o;

  modport master (
    output req_i, write_enable_i, addr_i, write_data_i,
    input  read_data_o
  );

  modport slave (
    input  req_i, write_enable_i, addr_i, write_data_i,
    output read_data_o
  );
endinterface
`default_nettype wire

// File: rtl/led_pwm_sb_ctrl_blink_timer.sv
`default_nettype none
// ============================================================================
// Module   : led_blink_timer
// Brief    : Half-period counter with phase flop for the LED blink mode
// Revision : 1.0 - initial release
// ============================================================================
module led_blink_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] half,
  input  logic        enable,
  input  logic        restart,
  output logic        phase
);

  logic [31:0] r_cnt;
  logic        r_phase;

  // The >= compare keeps the counter bounded even if HALF shrinks under it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt   <= 32'd0;
      r_phase <= 1'b1;
    end else if (restart || !enable) begin
      r_cnt   <= 32'd0;
      r_phase <= 1'b1;
    end else if (r_cnt >= half - 32'd1) begin
      r_cnt   <= 32'd0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 32'd1;
    end
  end

  assign phase = r_phase;

endmodule
`default_nettype wire

// File: rtl/led_pwm_sb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_pwm_sb_ctrl
// Brief    : Bus-mapped LED driver with enable mask, blink timer and PWM dimmer
// Revision : 1.0 - initial release
// ============================================================================
module led_pwm_sb_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int          N_LEDS    = 16,
  parameter int          PWM_W     = 8,
  parameter logic [31:0] BLINK_RST = 32'd10_000_000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  led_pwm_sb_ctrl_if.slave      bus,
  output logic [N_LEDS-1:0]     led_o
);

  localparam logic [PWM_W:0]   DUTY_MAX = {1'b1, {PWM_W{1'b0}}};
  localparam logic [PWM_W-1:0] PWM_ONE  = PWM_W'(1);

  logic [N_LEDS-1:0] r_value;
  led_mode_e         r_mode;
  logic [PWM_W:0]    r_duty;
  logic [31:0]       r_half;
  logic [PWM_W-1:0]  r_pwm_cnt;
  logic [N_LEDS-1:0] r_led;
  logic [31:0]       r_read_data;

  logic        w_wr, w_rd, w_soft_rst;
  logic        w_val_wr, w_mode_wr, w_duty_wr, w_half_wr;
  logic        w_restart, w_phase, w_dim_on, w_gate;
  logic [31:0] w_rd_data;

  assign w_wr       = bus.req_i &  bus.write_enable_i;
  assign w_rd       = bus.req_i & ~bus.write_enable_i;
  assign w_soft_rst = w_wr && (bus.addr_i == LED_RST_ADDR)  && (bus.write_data_i == 32'd1);
  assign w_val_wr   = w_wr && (bus.addr_i == LED_VAL_ADDR)  && fits_bits(bus.write_data_i, N_LEDS);
  assign w_mode_wr  = w_wr && (bus.addr_i == LED_MODE_ADDR) && fits_bits(bus.write_data_i, 2);
  assign w_duty_wr  = w_wr && (bus.addr_i == LED_DUTY_ADDR) && (bus.write_data_i <= 32'(DUTY_MAX));
  assign w_half_wr  = w_wr && (bus.addr_i == LED_HALF_ADDR) && (bus.write_data_i != 32'd0);

  // Soft reset reuses the timer restart path: both land on counter 0, phase 1.
  assign w_restart  = w_soft_rst | w_half_wr | (w_mode_wr & bus.write_data_i[MODE_BLINK_BIT]);

  led_blink_timer u_blink (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .half    (r_half),
    .enable  (r_mode[MODE_BLINK_BIT]),
    .restart (w_restart),
    .phase   (w_phase)
  );

  assign w_dim_on = ({1'b0, r_pwm_cnt} < r_duty);
  assign w_gate   = (r_mode[MODE_BLINK_BIT] ? w_phase  : 1'b1) &
                    (r_mode[MODE_DIM_BIT]   ? w_dim_on : 1'b1);

  always_comb begin
    w_rd_data = 32'd0;
    case (bus.addr_i)
      LED_VAL_ADDR:  w_rd_data = 32'(r_value);
      LED_MODE_ADDR: w_rd_data = 32'(r_mode);
      LED_DUTY_ADDR: w_rd_data = 32'(r_duty);
      LED_HALF_ADDR: w_rd_data = r_half;
      default:       w_rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_value     <= '0;
      r_mode      <= STATIC;
      r_duty      <= DUTY_MAX;
      r_half      <= BLINK_RST;
      r_pwm_cnt   <= '0;
      r_led       <= '0;
      r_read_data <= 32'd0;
    end else if (w_soft_rst) begin
      r_value     <= '0;
      r_mode      <= STATIC;
      r_duty      <= DUTY_MAX;
      r_half      <= BLINK_RST;
      r_pwm_cnt   <= '0;
      r_led       <= '0;
      r_read_data <= 32'd0;
    end else begin
      if (w_val_wr)  r_value <= bus.write_data_i[N_LEDS-1:0];
      if (w_mode_wr) r_mode  <= led_mode_e'(bus.write_data_i[1:0]);
      if (w_duty_wr) r_duty  <= bus.write_data_i[PWM_W:0];
      if (w_half_wr) r_half  <= bus.write_data_i;
      if (w_rd)      r_read_data <= w_rd_data;
      r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
      r_led     <= r_value & {N_LEDS{w_gate}};
    end
  end

  assign led_o           = r_led;
  assign bus.read_data_o = r_read_data;

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_sb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pwm_sb_ctrl
// Brief    : Self-checking bench: vector table, corner sequences, random vs model
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pwm_sb_ctrl;

  localparam int          N      = 16;
  localparam int          PERIOD = 256;
  localparam logic [31:0] HRST   = 32'd10_000_000;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] led;

  led_pwm_sb_ctrl_if bus();

  led_pwm_sb_ctrl #(.N_LEDS(N), .PWM_W(8), .BLINK_RST(HRST)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .led_o (led)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: registers plus the edge indices of the last blink restart and PWM zero.
  logic [N-1:0] m_value;
  logic [1:0]   m_mode;
  int           m_duty;
  logic [31:0]  m_half;
  longint       m_rs, m_base, e;
  logic [N-1:0] x_led;
  logic [31:0]  x_rd;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset(input longint at);
    m_value = '0; m_mode = 2'd0; m_duty = PERIOD; m_half = HRST;
    m_rs = at; m_base = at; x_led = '0; x_rd = 32'd0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a)
      32'h00:  return 32'(m_value);
      32'h04:  return 32'(m_mode);
      32'h08:  return 32'(m_duty);
      32'h0C:  return m_half;
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    logic         g;
    logic [N-1:0] n_led;
    logic [31:0]  n_rd, a, d;
    g = 1'b1;
    if (m_mode[0]) g = g & ((((e - m_rs) / longint'(m_half)) % 2) == 0);
    if (m_mode[1]) g = g & (((e - m_base) % PERIOD) < m_duty);
    n_led = g ? m_value : '0;
    n_rd  = x_rd;
    a = bus.addr_i; d = bus.write_data_i;
    if (bus.req_i && !bus.write_enable_i) n_rd = model_read(a);
    if (bus.req_i && bus.write_enable_i) begin
      case (a)
        32'h00: if (d < (32'd1 << N)) m_value = d[N-1:0];
        32'h04: if (d < 32'd4) begin m_mode = d[1:0]; if (d[0]) m_rs = e + 1; end
        32'h08: if (d <= PERIOD) m_duty = int'(d);
        32'h0C: if (d != 32'd0) begin m_half = d; m_rs = e + 1; end
        32'h24: if (d == 32'd1) begin model_reset(e + 1); n_led = '0; n_rd = 32'd0; end
        default: ;
      endcase
    end
    @(posedge clk); #1;
    e++;
    x_led = n_led; x_rd = n_rd;
    chk("led", 32'(led), 32'(x_led));
    chk("rdata", bus.read_data_o, x_rd);
  endtask

  task automatic op(input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.req_i = 1'b1; bus.write_enable_i = w; bus.addr_i = a; bus.write_data_i = d;
    tick();
    bus.req_i = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.req_i = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic count_on(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (led == {N{1'b1}}) c++;
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_led", 32'(led), 32'd0);
    chk("async_rdata", bus.read_data_o, 32'd0);
    @(posedge clk); #1;
    e++;
    model_reset(e);
    rst = 1'b0;
  endtask

  initial begin
    int c;
    bus.req_i = 1'b0; bus.write_enable_i = 1'b0; bus.addr_i = '0; bus.write_data_i = '0;
    rst = 1'b1;
    e = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset(0);
    rst = 1'b0;

    vt.push_back('{1'b0, 32'h08, 32'd0,        1'b1, 32'd256});
    vt.push_back('{1'b0, 32'h0C, 32'd0,        1'b1, 32'd10_000_000});
    vt.push_back('{1'b0, 32'h00, 32'd0,        1'b1, 32'd0});
    vt.push_back('{1'b0, 32'h04, 32'd0,        1'b1, 32'd0});
    vt.push_back('{1'b1, 32'h00, 32'hA5A5,     1'b0, 32'd0});
    vt.push_back('{1'b0, 32'h00, 32'd0,        1'b1, 32'hA5A5});
    vt.push_back('{1'b1, 32'h00, 32'h1_0000,   1'b0, 32'd0});
    vt.push_back('{1'b0, 32'h00, 32'd0,        1'b1, 32'hA5A5});
    vt.push_back('{1'b1, 32'h04, 32'd4,        1'b0, 32'd0});
    vt.push_back('{1'b0, 32'h04, 32'd0,        1'b1, 32'd0});
    vt.push_back('{1'b1, 32'h08, 32'd257,      1'b0, 32'd0});
    vt.push_back('{1'b0, 32'h08, 32'd0,        1'b1, 32'd256});
    vt.push_back('{1'b1, 32'h08, 32'd0,        1'b0, 32'd0});
    vt.push_back('{1'b0, 32'h08, 32'd0,        1'b1, 32'd0});
    vt.push_back('{1'b1, 32'h08, 32'd256,      1'b0, 32'd0});
    vt.push_back('{1'b0, 32'h08, 32'd0,        1'b1, 32'd256});
    vt.push_back('{1'b1, 32'h0C, 32'd0,        1'b0, 32'd0});
    vt.push_back('{1'b0, 32'h0C, 32'd0,        1'b1, 32'd10_000_000});
    vt.push_back('{1'b1, 32'h0C, 32'd7,        1'b0, 32'd0});
    vt.push_back('{1'b0, 32'h0C, 32'd0,        1'b1, 32'd7});
    vt.push_back('{1'b0, 32'h10, 32'd0,        1'b1, 32'd0});
    vt.push_back('{1'b0, 32'h01, 32'd0,        1'b1, 32'd0});
    vt.push_back('{1'b0, 32'h24, 32'd0,        1'b1, 32'd0});
    vt.push_back('{1'b1, 32'h04, 32'd3,        1'b0, 32'd0});
    vt.push_back('{1'b0, 32'h04, 32'd0,        1'b1, 32'd3});
    vt.push_back('{1'b1, 32'h24, 32'd2,        1'b0, 32'd0});
    vt.push_back('{1'b0, 32'h04, 32'd0,        1'b1, 32'd3});
    vt.push_back('{1'b1, 32'h24, 32'd1,        1'b0, 32'd0});
    vt.push_back('{1'b0, 32'h00, 32'd0,        1'b1, 32'd0});
    vt.push_back('{1'b0, 32'h04, 32'd0,        1'b1, 32'd0});
    vt.push_back('{1'b0, 32'h08, 32'd0,        1'b1, 32'd256});
    vt.push_back('{1'b0, 32'h0C, 32'd0,        1'b1, 32'd10_000_000});

    // Async reset must clear visibly non-zero outputs before any clock edge.
    op(1'b1, 32'h00, 32'h1234);
    idle(1);
    chk("pre_reset_led", 32'(led), 32'h1234);
    op(1'b0, 32'h00, 32'd0);
    chk("pre_reset_rd", bus.read_data_o, 32'h1234);
    async_reset();

    foreach (vt[i]) begin
      op(vt[i].we, vt[i].addr, vt[i].wd);
      if (vt[i].chk) chk($sformatf("tbl%0d", i), bus.read_data_o, vt[i].exp_rd);
    end

    // Static: one-cycle lag from write to led, out-of-range value ignored.
    op(1'b1, 32'h00, 32'hA5A5);
    chk("static_lag", 32'(led), 32'd0);
    idle(1);
    chk("static_led", 32'(led), 32'hA5A5);
    op(1'b1, 32'h00, 32'h1_0000);
    idle(1);
    chk("static_ignored", 32'(led), 32'hA5A5);

    // Blink with HALF=4, then HALF=2 written mid-count.
    op(1'b1, 32'h0C, 32'd4);
    op(1'b1, 32'h00, 32'hFFFF);
    op(1'b1, 32'h04, 32'd1);
    for (int k = 1; k <= 16; k++) begin
      idle(1);
      chk($sformatf("blink4_%0d", k), 32'(led), (((k - 1) / 4) % 2 == 0) ? 32'hFFFF : 32'd0);
    end
    idle(1);
    op(1'b1, 32'h0C, 32'd2);
    for (int k = 1; k <= 6; k++) begin
      idle(1);
      chk($sformatf("blink2_%0d", k), 32'(led), (((k - 1) / 2) % 2 == 0) ? 32'hFFFF : 32'd0);
    end

    // Dim: on-cycles per PWM period equal DUTY; 257 is rejected.
    op(1'b1, 32'h04, 32'd2);
    op(1'b1, 32'h08, 32'd64);
    idle(1);
    count_on(PERIOD, c); chk("dim64", c, 32'd64);
    op(1'b1, 32'h08, 32'd257);
    idle(1);
    count_on(PERIOD, c); chk("dim257_ignored", c, 32'd64);
    op(1'b1, 32'h08, 32'd0);
    idle(1);
    count_on(PERIOD, c); chk("dim0", c, 32'd0);
    op(1'b1, 32'h08, 32'd256);
    idle(1);
    count_on(PERIOD, c); chk("dim256", c, 32'd256);

    // Blink+dim: only the 512-cycle on-phase carries PWM, 128 of every 256.
    op(1'b1, 32'h0C, 32'd512);
    op(1'b1, 32'h08, 32'd128);
    op(1'b1, 32'h04, 32'd3);
    idle(1);
    count_on(1024, c); chk("blink_dim", c, 32'd256);

    for (int i = 0; i < 1500; i++) begin
      int          sel;
      logic        w;
      logic [31:0] a, d;
      if (i == 700) async_reset();
      sel = $urandom_range(0, 9);
      w   = 1'($urandom_range(0, 1));
      a   = 32'h0; d = 32'h0;
      case (sel)
        0: begin a = 32'h00; d = $urandom_range(0, 32'h1_FFFF); end
        1: begin a = 32'h04; d = $urandom_range(0, 5); end
        2: begin a = 32'h08; d = $urandom_range(0, 260); end
        3: begin a = 32'h0C; d = $urandom_range(0, 9); end
        4: begin a = 32'h24; d = ($urandom_range(0, 15) == 0) ? 32'd1 : $urandom_range(2, 3); end
        5: begin a = 32'h10; d = $urandom; end
        default: ;
      endcase
      if (sel <= 5) op(w, a, d);
      else idle(1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_pwm_sb_ctrl.md
# led_pwm_sb_ctrl

Parametrised LED peripheral on the system bus, successor of the single-mode LED controller. Drives `N_LEDS` outputs with a per-LED enable mask, a programmable blink timer and a global PWM dimmer, each selectable independently through a mode register. It sits behind the system-bus decoder (word-offset addresses) alongside the other memory-mapped peripherals of the interrupt-subsystem SoC.

## Interface
- `N_LEDS`, 16: number of LED outputs, 1..32.
- `PWM_W`, 8: PWM counter width; duty range 0..2^PWM_W.
- `BLINK_RST`, 32'd10_000_000: reset value of the blink half-period, in clock cycles.

- `clk_i` in 1: the only clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_i` in 1: bus request, one access per cycle.
- `write_enable_i` in 1: 1 = write, 0 = read.
- `addr_i` in 32: byte offset within the peripheral.
- `write_data_i` in 32: write data.
- `read_data_o` out 32: registered read data.
- `led_o` out `N_LEDS`: registered LED drive.

## Operation
- Register map; a write outside the valid range is ignored and leaves the register unchanged:
  - 0x00 VALUE, `N_LEDS` bits. Valid if `write_data_i < 2^N_LEDS`.
  - 0x04 MODE, 2 bits. Bit0 = blink, bit1 = dim. Valid if `< 4`.
  - 0x08 DUTY, `PWM_W+1` bits. Valid if `<= 2^PWM_W`.
  - 0x0C HALF, 32 bits, blink half-period. Valid if `!= 0`.
  - 0x24 RESET, write-only. Writing exactly 1 performs a soft reset. Writing any other value is ignored.
- Soft reset has the same effect as `rst_i`, applied synchronously at the next clock edge.
- Reset values: VALUE 0, MODE 0, DUTY 2^PWM_W, HALF `BLINK_RST`, `read_data_o` 0, `led_o` 0, blink counter 0, blink phase 1, PWM counter 0.
- Blink timer:
  - Runs only while MODE.bit0 = 1. While bit0 = 0, the counter is held at 0 and the phase at 1.
  - The counter counts 0..HALF-1. On reaching HALF-1 it wraps to 0 and toggles the phase.
  - A valid write to HALF, or a MODE write that sets bit0, clears the counter to 0 and sets the phase to 1 on the next edge.
  - If HALF is written below the current count, the restart takes effect, so there is no wrap overrun.
- PWM counter:
  - `PWM_W` bits, free-running, wraps from 2^PWM_W-1 to 0.
  - dim_on = (pwm_cnt < DUTY). DUTY = 0 gives always off; DUTY = 2^PWM_W gives always on.
- Gate = (bit0 ? phase : 1) & (bit1 ? dim_on : 1). Next `led_o` = VALUE & {N_LEDS{gate}}.
- Reads:
  - At mapped addresses 0x00–0x0C, a read loads the zero-extended register value into `read_data_o`.
  - At 0x24 or any unmapped address, a read loads 0.
  - With no read request, `read_data_o` holds its value.
  - Writes never change `read_data_o`, except through a reset.

## Timing
- Write: register updated at edge N (the edge at which the request is sampled). `led_o` reflects the new value at edge N+1.
- Read: request sampled at edge N; `read_data_o` is valid after edge N and stays stable until the next read or reset.
- `rst_i` assertion clears all state and outputs immediately, without waiting for a clock edge. Deassertion is taken by the next edge.
- Blink, with HALF = H: the phase toggles every H cycles. `led_o` lags the phase by one cycle. Full blink period = 2H.
- PWM period = 2^PWM_W cycles. On-time = DUTY cycles per period.
- A soft-reset write wins over everything in the same cycle.
- Reset mid-blink or mid-PWM discards partial counts. Counting restarts from the reset values.

## Structure
- Package `led_ctrl_pkg` holds:
  - address constants: `LED_VAL_ADDR`, `LED_MODE_ADDR`, `LED_DUTY_ADDR`, `LED_HALF_ADDR`, `LED_RST_ADDR`;
  - the mode bit positions;
  - `typedef enum logic [1:0]` for mode values: STATIC, BLINK, DIM, BLINK_DIM.
- One sub-module, `led_blink_timer`. Inputs: HALF, enable, restart. Output: phase. It contains the 32-bit counter and the phase flop.
- The PWM counter, register file and read mux live in the top module.

## Test plan
- Reset (async): assert `rst_i` mid-cycle -> `led_o` = 0 and `read_data_o` = 0 immediately; read DUTY -> 256 (PWM_W = 8); read HALF -> 10_000_000.
- Static mode: write VALUE = 0xA5A5, MODE = 0 -> `led_o` = 0xA5A5 one cycle later. Write VALUE = 0x1_0000 -> ignored, VALUE still 0xA5A5.
- Blink: HALF = 4, MODE = 1, VALUE = 0xFFFF -> `led_o` alternates between 0xFFFF for 4 cycles and 0 for 4 cycles. Rewrite HALF = 2 mid-count -> restart with 2-cycle phases starting with on.
- Dim: DUTY = 64, MODE = 2 -> exactly 64 on-cycles per 256. DUTY = 0 -> always 0. DUTY = 256 -> always VALUE. DUTY = 257 -> ignored.
- Blink+dim: MODE = 3, HALF = 512, DUTY = 128 -> PWM pattern visible only in on-phases.
- Soft reset and reads: write 0x24 = 1 -> all registers at reset values next cycle. Write 0x24 = 2 -> no effect. Read 0x10 -> 0. Read 0x04 after MODE = 3 -> 3.
